// File: rtl/msi_dir_pkg.sv
// Shared type codes, directory encodings and FSM states for the MSI home-node controller.
package msi_dir_pkg;

    localparam int unsigned DIR_NODES  = 4;
    localparam int unsigned DIR_ADDR_W = 4;
    localparam int unsigned DIR_DATA_W = 4;

    typedef enum logic [2:0] {
        TypeNone      = 3'b000,
        ReqReadMiss   = 3'b001,
        ReqWriteMiss  = 3'b010,
        MsgFetch      = 3'b011,
        MsgFetchInv   = 3'b100,
        MsgInvalidate = 3'b101,
        ReqWriteBack  = 3'b110
    } msi_type_e;

    typedef enum logic [1:0] {
        DirUncached = 2'b00,
        DirShared   = 2'b01,
        DirModified = 2'b10
    } dir_state_e;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StWaitAck,
        StReply
    } fsm_state_e;

    // In Modified, sharers holds the one-hot owner.
    typedef struct packed {
        dir_state_e             state;
        logic [DIR_NODES-1:0]   sharers;
    } dir_entry_t;

endpackage

// File: rtl/msi_dir_if.sv
// Request/coherence/reply bundle between the L1 caches (master) and the home node (slave).
interface msi_dir_if #(
    parameter int unsigned NODES  = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
);
    localparam int unsigned NodeW = (NODES > 1) ? $clog2(NODES) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [NodeW-1:0]  req_node;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_data;

    logic              msg_valid;
    logic [2:0]        msg_type;
    logic [NODES-1:0]  msg_target;
    logic [ADDR_W-1:0] msg_address;

    logic              ack_valid;
    logic [DATA_W-1:0] ack_data;

    logic              resp_valid;
    logic [NodeW-1:0]  resp_node;
    logic [ADDR_W-1:0] resp_address;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_node, req_type, req_address, req_data, ack_valid, ack_data,
        input  req_ready, msg_valid, msg_type, msg_target, msg_address,
        input  resp_valid, resp_node, resp_address, resp_data
    );

    modport slave (
        input  req_valid, req_node, req_type, req_address, req_data, ack_valid, ack_data,
        output req_ready, msg_valid, msg_type, msg_target, msg_address,
        output resp_valid, resp_node, resp_address, resp_data
    );

endinterface

// File: rtl/msi_dir_store.sv
// Directory entries plus backing memory: one combinational read port, one synchronous write port.
module msi_dir_store
    import msi_dir_pkg::*;
#(
    parameter int unsigned ADDR_W = DIR_ADDR_W,
    parameter int unsigned DATA_W = DIR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output dir_entry_t        rd_entry,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  dir_entry_t        wr_entry,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    dir_entry_t        dir_q [Depth];
    logic [DATA_W-1:0] mem_q [Depth];

    assign rd_entry = dir_q[rd_addr];
    assign rd_data  = mem_q[rd_addr];

    // Memory word a powers up holding its own address so fills are traceable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                dir_q[i] <= '0;
                mem_q[i] <= DATA_W'(i);
            end
        end else if (wr_en) begin
            dir_q[wr_addr] <= wr_entry;
            mem_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/msi_directory_controller.sv
// MSI home-node directory controller: serialises cache misses/writebacks, issues
// Fetch/Invalidate/FetchInvalidate to remote caches and returns fill data.
module msi_directory_controller
    import msi_dir_pkg::*;
#(
    parameter int unsigned NODES  = DIR_NODES,
    parameter int unsigned ADDR_W = DIR_ADDR_W,
    parameter int unsigned DATA_W = DIR_DATA_W
) (
    input logic     clk,
    input logic     rst,
    msi_dir_if.slave bus
);

    localparam int unsigned NodeW = (NODES > 1) ? $clog2(NODES) : 1;

    fsm_state_e        state_q;
    logic [NodeW-1:0]  req_node_q;
    logic [2:0]        req_type_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    dir_entry_t        new_entry_q;
    logic [DATA_W-1:0] new_data_q;
    logic              commit_q;

    logic              req_ready_q;
    logic              msg_valid_q;
    logic [2:0]        msg_type_q;
    logic [NODES-1:0]  msg_target_q;
    logic [ADDR_W-1:0] msg_addr_q;
    logic              resp_valid_q;
    logic [NodeW-1:0]  resp_node_q;
    logic [ADDR_W-1:0] resp_addr_q;
    logic [DATA_W-1:0] resp_data_q;

    dir_entry_t        rd_entry;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;

    logic [NODES-1:0]  req_mask;
    logic [NODES-1:0]  others;
    logic              is_owner;
    logic              dec_msg;
    logic [2:0]        dec_msg_type;
    logic [NODES-1:0]  dec_target;
    logic              dec_reply;
    logic              dec_commit;
    dir_entry_t        dec_entry;

    assign wr_en = (state_q == StReply) && commit_q;

    msi_dir_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (req_addr_q),
        .rd_entry (rd_entry),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (req_addr_q),
        .wr_entry (new_entry_q),
        .wr_data  (new_data_q)
    );

    assign req_mask = NODES'(1) << req_node_q;
    assign others   = rd_entry.sharers & ~req_mask;
    assign is_owner = (rd_entry.state == DirModified) && (rd_entry.sharers == req_mask);

    always_comb begin
        dec_msg      = 1'b0;
        dec_msg_type = MsgFetch;
        dec_target   = '0;
        dec_reply    = 1'b0;
        dec_commit   = 1'b0;
        dec_entry    = rd_entry;
        case (req_type_q)
            ReqReadMiss: begin
                dec_reply = 1'b1;
                if (rd_entry.state == DirModified && !is_owner) begin
                    dec_msg      = 1'b1;
                    dec_msg_type = MsgFetch;
                    dec_target   = rd_entry.sharers;
                    dec_commit   = 1'b1;
                    dec_entry    = '{state: DirShared, sharers: rd_entry.sharers | req_mask};
                end else if (rd_entry.state != DirModified) begin
                    dec_commit = 1'b1;
                    dec_entry  = '{state: DirShared, sharers: rd_entry.sharers | req_mask};
                end
            end
            ReqWriteMiss: begin
                dec_reply  = 1'b1;
                dec_commit = !is_owner;
                dec_entry  = '{state: DirModified, sharers: req_mask};
                if (rd_entry.state == DirModified && !is_owner) begin
                    dec_msg      = 1'b1;
                    dec_msg_type = MsgFetchInv;
                    dec_target   = rd_entry.sharers;
                end else if (rd_entry.state == DirShared && others != '0) begin
                    dec_msg      = 1'b1;
                    dec_msg_type = MsgInvalidate;
                    dec_target   = others;
                end
            end
            ReqWriteBack: begin
                // Stale writebacks (requester no longer owner) fall through with no commit.
                if (is_owner) begin
                    dec_commit = 1'b1;
                    dec_entry  = '{state: DirUncached, sharers: '0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_node_q   <= '0;
            req_type_q   <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            new_entry_q  <= '0;
            new_data_q   <= '0;
            commit_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            msg_valid_q  <= 1'b0;
            msg_type_q   <= '0;
            msg_target_q <= '0;
            msg_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_node_q  <= '0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        req_node_q  <= bus.req_node;
                        req_type_q  <= bus.req_type;
                        req_addr_q  <= bus.req_address;
                        req_data_q  <= bus.req_data;
                        req_ready_q <= 1'b0;
                        state_q     <= StLookup;
                    end
                end
                StLookup: begin
                    new_entry_q <= dec_entry;
                    new_data_q  <= (req_type_q == ReqWriteBack) ? req_data_q : rd_data;
                    commit_q    <= dec_commit;
                    resp_node_q <= req_node_q;
                    resp_addr_q <= req_addr_q;
                    resp_data_q <= rd_data;
                    if (dec_msg) begin
                        msg_valid_q  <= 1'b1;
                        msg_type_q   <= dec_msg_type;
                        msg_target_q <= dec_target;
                        msg_addr_q   <= req_addr_q;
                        state_q      <= StWaitAck;
                    end else begin
                        resp_valid_q <= dec_reply;
                        state_q      <= StReply;
                    end
                end
                StWaitAck: begin
                    if (bus.ack_valid) begin
                        msg_valid_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        // Invalidate acks carry no data; memory already holds the clean copy.
                        if (msg_type_q != MsgInvalidate) begin
                            new_data_q  <= bus.ack_data;
                            resp_data_q <= bus.ack_data;
                        end
                        state_q <= StReply;
                    end
                end
                StReply: begin
                    resp_valid_q <= 1'b0;
                    commit_q     <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.msg_valid    = msg_valid_q;
    assign bus.msg_type     = msg_type_q;
    assign bus.msg_target   = msg_target_q;
    assign bus.msg_address  = msg_addr_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_node    = resp_node_q;
    assign bus.resp_address = resp_addr_q;
    assign bus.resp_data    = resp_data_q;

endmodule

// File: doc/msi_directory_controller.md
Name: msi_directory_controller

Overview:
Home-node directory and memory controller for the MSI directory protocol, directly downstream of the per-processor L1 cache controllers. Accepts ReadMiss, WriteMiss and WriteBack requests from the caches one at a time. Tracks per-block sharer state and issues Fetch, Invalidate and FetchInvalidate messages to remote caches. Returns block data to the requester, feeding the cache fill path (AddressMemory/DataMemory).

Parameters:
NODES, 4, number of cache nodes; sharer vector width
ADDR_W, 4, block address width; directory depth = 2**ADDR_W
DATA_W, 4, block data width

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high
ReqValid  in  1  request present
ReqReady  out  1  controller can accept a request
ReqNode  in  clog2(NODES)  requesting node id
ReqType  in  3  001 ReadMiss, 010 WriteMiss, 110 WriteBack
ReqAddress  in  ADDR_W  block address
ReqData  in  DATA_W  writeback data; ignored for other types
MsgValid  out  1  coherence message to remote caches
MsgType  out  3  011 Fetch, 100 FetchInvalidate, 101 Invalidate
MsgTarget  out  NODES  one-hot owner or sharer mask
MsgAddress  out  ADDR_W  block targeted
AckValid  in  1  aggregate acknowledge from all targets
AckData  in  DATA_W  owner data; valid with Fetch and FetchInvalidate acks
RespValid  out  1  one-cycle data reply pulse
RespNode  out  clog2(NODES)  destination node
RespAddress  out  ADDR_W  reply address (AddressMemory)
RespData  out  DATA_W  reply data (DataMemory)

Behaviour:
- Reset, synchronous and active-high:
  - All entries go to Uncached (00) with sharers 0.
  - Memory word a is set to a (zero-extended).
  - FSM goes to IDLE and ReqReady=1.
  - All other outputs go to 0.
  - Reset mid-transaction abandons the transaction; no reply is sent.
- Directory state per block: 00 Uncached, 01 Shared, 10 Modified. In Modified, sharers is the one-hot owner.
- FSM states: IDLE, LOOKUP, WAIT_ACK, REPLY.
  - IDLE: ReqReady=1. A request is accepted on the edge where ReqValid&ReqReady. The request is latched, then LOOKUP.
  - LOOKUP takes one cycle and reads the directory entry. It then either decides the action and goes to WAIT_ACK (MsgValid raised), or goes straight to REPLY.
  - WAIT_ACK: MsgType, MsgTarget and MsgAddress are held stable and MsgValid stays 1 until the edge with AckValid=1. That edge captures AckData, then REPLY. AckValid in any other state is ignored.
  - REPLY takes one cycle. It commits the directory and memory updates, pulses RespValid when a reply is required, then returns to IDLE.
- ReadMiss:
  - Uncached or Shared: reply with memory data. State becomes Shared; sharers |= req.
  - Modified, owner≠req: send Fetch to the owner. On ack, memory ← AckData and reply with AckData. State becomes Shared; sharers = owner|req.
  - Modified, owner==req: reply with memory data; no state change.
- WriteMiss:
  - Uncached: reply with memory data; Modified, owner=req.
  - Shared with sharers&~req ≠ 0: send Invalidate with MsgTarget = sharers&~req and wait for the ack. Then reply with memory data; Modified, owner=req.
  - Shared, req is the only sharer: no message is sent; behaves as the Uncached case.
  - Modified, owner≠req: send FetchInvalidate to the owner. On ack, memory ← AckData and reply with AckData; Modified, owner=req.
  - Modified, owner==req: reply with memory data; no change.
- WriteBack:
  - Modified with owner==req: memory ← ReqData; state Uncached, sharers 0. No reply.
  - Any other state (stale writeback): no update and no reply.
  - Both cases pass through LOOKUP and REPLY.
- Undefined ReqType is accepted and dropped with no update.
- Latency, accept edge = N:
  - No-message case: RespValid high in cycle N+2.
  - Message case: MsgValid high from cycle N+2; RespValid high the cycle after the ack edge.
- Only one transaction is in flight. ReqReady=0 from LOOKUP through REPLY.

Decomposition:
- Package msi_dir_pkg holds:
  - request and message type codes (000–110);
  - directory state codes;
  - FSM state enum;
  - the directory-entry struct {state[1:0], sharers[NODES-1:0]}.
- Sub-module msi_dir_store holds the directory plus the memory array, with one combinational read port and one synchronous write port (entry and data written together in REPLY). Its reset initialisation is as above.

Test Plan:
- Reset, then ReadMiss node0 addr 7 → RespValid at N+2, RespNode=0, RespData=7; entry 7 = Shared, sharers 0001.
- Node1 ReadMiss addr 4, node2 ReadMiss addr 4, then node1 WriteMiss addr 4 → Invalidate with MsgTarget=0100. After the ack: RespData=4, entry Modified, sharers 0010.
- Node3 WriteMiss addr 2, then node0 ReadMiss addr 2 → Fetch to 1000; ack with AckData=9 → RespData=9, memory[2]=9, entry Shared, sharers 1001.
- Node3 owns addr 5 (Modified), node1 WriteMiss addr 5 → FetchInvalidate to 1000; AckData=6 → RespData=6, owner 0010. A later WriteBack from node3 with data 3 is dropped: memory[5] stays 6.
- Owner WriteBack of 0xC to addr 5 → no RespValid; entry Uncached; a subsequent ReadMiss returns 0xC.
- Assert Reset while in WAIT_ACK → next cycle MsgValid=0, ReqReady=1, no RespValid; a ReadMiss of that address returns the address value and Shared state.
